frame_fetch: RTL and testbench

FRAME_FETCH -- requirements
Module: frame_fetch

---
 rtl/frame_fetch_pkg.sv | 62 ++++++
 rtl/frame_fetch_if.sv | 12 +
 rtl/frame_fetch_pipe_delay.sv | 31 +++
 rtl/frame_fetch.sv | 201 ++++++++++++++++++++
 tb/tb_frame_fetch.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_fetch_pkg.sv
// frame_fetch_pkg: shared constants, freeze FSM state type, timing bundle,
// colour-bar table and pixel helper functions for the frame fetch path.
// The bar table is consumed only when FRAME_FETCH_TEST_PATTERN_EN is defined.
package frame_fetch_pkg;

    // Native frame-buffer geometry (1x display mode)
    localparam int FB_WIDTH  = 240;
    localparam int FB_HEIGHT = 320;

    // Display-region limits for the scaled modes
    localparam int SCALE2X_W = 480;
    localparam int SCALE2X_H = 480;
    localparam int SCALE83_W = 640;
    localparam int SCALE83_H = 480;

    // Raster position in to display pixel out
    localparam int PIPE_LAT = 6;

    localparam int H_W    = 11;
    localparam int V_W    = 10;
    localparam int ADDR_W = 17;
    localparam int DOUT_W = 16;
    localparam int PIX_W  = 12;

    typedef enum logic [1:0] {
        LIVE        = 2'd0,
        FREEZE_PEND = 2'd1,
        FROZEN      = 2'd2,
        THAW_PEND   = 2'd3
    } fetch_state_t;

    // Raster timing and region flag travelling together down the delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic region;
    } timing_t;

    // RGB444 colour bars, indexed by hcount[9:7]
    localparam logic [PIX_W-1:0] BAR_TABLE [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Keep the top four bits of each RGB565 channel
    function automatic logic [PIX_W-1:0] rgb565_to_444(input logic [DOUT_W-1:0] c);
        return {c[15:12], c[10:7], c[4:1]};
    endfunction

    // Visible image area for the given scale mode; 3 shares the 8/3x limits
    function automatic logic in_region(input logic [1:0]     scale,
                                       input logic [H_W-1:0] h,
                                       input logic [V_W-1:0] v);
        case (scale)
            2'd0:    return (h < H_W'(FB_WIDTH))  && (v < V_W'(FB_HEIGHT));
            2'd1:    return (h < H_W'(SCALE2X_W)) && (v < V_W'(SCALE2X_H));
            default: return (h < H_W'(SCALE83_W)) && (v < V_W'(SCALE83_H));
        endcase
    endfunction

endpackage

// File: rtl/frame_fetch_if.sv
// frame_fetch_if: frame-buffer read port. The fetcher (master) drives the
// read address; the memory (slave) returns RGB565 data two cycles later.
interface frame_fetch_if;
    import frame_fetch_pkg::*;

    logic [ADDR_W-1:0] bram_addr_out;
    logic [DOUT_W-1:0] bram_dout_in;

    modport master (output bram_addr_out, input bram_dout_in);
    modport slave  (input bram_addr_out, output bram_dout_in);

endinterface

// File: rtl/frame_fetch_pipe_delay.sv
// pipe_delay: fixed-depth register delay line with asynchronous active-low
// clear. Used for every raster-aligned side signal in frame_fetch.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; clear every stage on reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_fetch.sv
// frame_fetch: turns frame-buffer reads into RGB444 display pixels with the
// raster timing realigned to the 6-cycle fetch latency, and runs the
// freeze/thaw FSM that gates camera writes on frame boundaries.
// Optional: FRAME_FETCH_TEST_PATTERN_EN replaces scale-3 pixels with colour bars.
module frame_fetch
    import frame_fetch_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [1:0]        scale_in,
    input  logic [H_W-1:0]    hcount_in,
    input  logic [V_W-1:0]    vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              blank_in,
    input  logic [ADDR_W-1:0] pixel_addr_in,
    input  logic              freeze_in,
    frame_fetch_if.master     fb,
    output logic              frozen_out,
    output logic              cam_we_gate_out,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              blank_out
);

    // ------------------------------------------------------------------
    // Raster side-band: region flag from the raw position, then delayed
    // so it lines up with read data (t+5) ahead of the output register.
    // ------------------------------------------------------------------
    timing_t timing_now;
    timing_t timing_dly;

    // Bundle raster timing with the region decision for this position
    always_comb begin
        timing_now        = '0;
        timing_now.hsync  = hsync_in;
        timing_now.vsync  = vsync_in;
        timing_now.blank  = blank_in;
        timing_now.region = in_region(scale_in, hcount_in, vcount_in);
    end

    pipe_delay #(
        .WIDTH ($bits(timing_t)),
        .DEPTH (PIPE_LAT - 1)
    ) u_timing_dly (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .d_i     (timing_now),
        .q_o     (timing_dly)
    );

`ifdef FRAME_FETCH_TEST_PATTERN_EN
    // Scale mode and bar index travel with the pixel so a mid-frame scale
    // change only affects pixels that entered after it.
    logic [4:0] pat_dly;
    logic [1:0] pat_scale;
    logic [2:0] pat_bar;

    pipe_delay #(
        .WIDTH (5),
        .DEPTH (PIPE_LAT - 1)
    ) u_pattern_dly (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .d_i     ({scale_in, hcount_in[9:7]}),
        .q_o     (pat_dly)
    );

    assign pat_scale = pat_dly[4:3];
    assign pat_bar   = pat_dly[2:0];
`endif

    // ------------------------------------------------------------------
    // Read address: one register between address generator and memory.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] bram_addr_q;

    // Register the generated address toward the frame buffer
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bram_addr_q <= '0;
        end else begin
            bram_addr_q <= pixel_addr_in;
        end
    end

    assign fb.bram_addr_out = bram_addr_q;

    // ------------------------------------------------------------------
    // Output stage: colour conversion and blanking, registered at t+6.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] pixel_d;
    logic [PIX_W-1:0] pixel_q;
    logic             hsync_q;
    logic             vsync_q;
    logic             blank_q;

    // Select memory colour, bar colour or black for the aligned pixel
    always_comb begin
        pixel_d = '0;
        if (timing_dly.region && !timing_dly.blank) begin
            pixel_d = rgb565_to_444(fb.bram_dout_in);
`ifdef FRAME_FETCH_TEST_PATTERN_EN
            if (pat_scale == 2'd3) begin
                pixel_d = BAR_TABLE[pat_bar];
            end
`endif
        end
    end

    // Register pixel and timing together; reset shows a blanked black screen
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_q <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            blank_q <= 1'b1;
        end else begin
            pixel_q <= pixel_d;
            hsync_q <= timing_dly.hsync;
            vsync_q <= timing_dly.vsync;
            blank_q <= timing_dly.blank;
        end
    end

    assign pixel_out = pixel_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign blank_out = blank_q;

    // ------------------------------------------------------------------
    // Freeze FSM: requests take effect only at a frame boundary so the
    // frame buffer never holds a half-written image.
    // ------------------------------------------------------------------
    fetch_state_t state_q;
    logic         gate_q;
    logic         frozen_q;
    logic         frame_start;

    assign frame_start = (hcount_in == '0) && (vcount_in == '0);

    // Advance freeze state and register the write gate / frozen flag with it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= LIVE;
            gate_q   <= 1'b1;
            frozen_q <= 1'b0;
        end else begin
            case (state_q)
                LIVE: begin
                    // A request wins over a coincident frame start; it
                    // waits for the next boundary.
                    if (freeze_in) begin
                        state_q <= FREEZE_PEND;
                    end
                    gate_q   <= 1'b1;
                    frozen_q <= 1'b0;
                end
                FREEZE_PEND: begin
                    if (!freeze_in) begin
                        state_q  <= LIVE;
                        gate_q   <= 1'b1;
                        frozen_q <= 1'b0;
                    end else if (frame_start) begin
                        state_q  <= FROZEN;
                        gate_q   <= 1'b0;
                        frozen_q <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (!freeze_in) begin
                        state_q  <= THAW_PEND;
                        gate_q   <= 1'b0;
                        frozen_q <= 1'b0;
                    end
                end
                THAW_PEND: begin
                    if (freeze_in) begin
                        state_q  <= FROZEN;
                        gate_q   <= 1'b0;
                        frozen_q <= 1'b1;
                    end else if (frame_start) begin
                        state_q  <= LIVE;
                        gate_q   <= 1'b1;
                        frozen_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= LIVE;
                    gate_q   <= 1'b1;
                    frozen_q <= 1'b0;
                end
            endcase
        end
    end

    assign cam_we_gate_out = gate_q;
    assign frozen_out      = frozen_q;

endmodule

// File: tb/tb_frame_fetch.sv
// tb_frame_fetch: directed vectors with hand-computed pixels; expected
// responses are queued with their due cycle and checked by a monitor.
module tb_frame_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  scale;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hs, vs, bl;
    logic [16:0] paddr;
    logic        freeze;
    logic        frozen, gate;
    logic [11:0] pix;
    logic        hso, vso, blo;

    always #5 clk = ~clk;

    frame_fetch_if fb_if ();

    frame_fetch dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .scale_in        (scale),
        .hcount_in       (hcount),
        .vcount_in       (vcount),
        .hsync_in        (hs),
        .vsync_in        (vs),
        .blank_in        (bl),
        .pixel_addr_in   (paddr),
        .freeze_in       (freeze),
        .fb              (fb_if),
        .frozen_out      (frozen),
        .cam_we_gate_out (gate),
        .pixel_out       (pix),
        .hsync_out       (hso),
        .vsync_out       (vso),
        .blank_out       (blo)
    );

    typedef struct {
        int          due;
        logic [16:0] val;
        int          id;
    } exp_t;

    typedef struct {
        int          h;
        int          v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [1:0]  sc;
        logic [15:0] dout;
        logic [11:0] epix;
    } vec_t;

`ifdef FRAME_FETCH_TEST_PATTERN_EN
    localparam logic [11:0] SC3_PIX = 12'hFF0;
`else
    localparam logic [11:0] SC3_PIX = 12'h14A;
`endif

    exp_t        qpix[$];
    exp_t        qaddr[$];
    exp_t        qfsm[$];
    logic [16:0] addr_sched[int];
    logic [15:0] dout_sched[int];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          nfsm = 0;
    exp_t        e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int id, input logic [16:0] got, input logic [16:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s #%0d cycle %0d: got %h, expected %h", nm, id, cyc, got, want);
    endtask

    task automatic missed(input string nm, input int id, input int due);
        total++;
        $display("FAIL %s #%0d: due cycle %0d never checked", nm, id, due);
    endtask

    // Address generator / frame-buffer model: replay scheduled values
    initial begin
        paddr = 17'h15555;
        fb_if.bram_dout_in = 16'hFFFF;
        forever begin
            @(posedge clk);
            #1;
            if (addr_sched.exists(cyc)) begin
                paddr = addr_sched[cyc];
                addr_sched.delete(cyc);
            end else paddr = 17'h15555;
            if (dout_sched.exists(cyc)) begin
                fb_if.bram_dout_in = dout_sched[cyc];
                dout_sched.delete(cyc);
            end else fb_if.bram_dout_in = 16'hFFFF;
        end
    end

    // Monitor: compare every expectation that falls due this cycle
    always @(negedge clk) begin
        while (qpix.size() > 0 && qpix[0].due <= cyc) begin
            e = qpix.pop_front();
            if (e.due != cyc) missed("pix", e.id, e.due);
            else check("pix", e.id, {2'b00, blo, vso, hso, pix}, e.val);
        end
        while (qaddr.size() > 0 && qaddr[0].due <= cyc) begin
            e = qaddr.pop_front();
            if (e.due != cyc) missed("bram_addr", e.id, e.due);
            else check("bram_addr", e.id, fb_if.bram_addr_out, e.val);
        end
        while (qfsm.size() > 0 && qfsm[0].due <= cyc) begin
            e = qfsm.pop_front();
            if (e.due != cyc) missed("fsm", e.id, e.due);
            else check("fsm{frozen,gate}", e.id, {15'b0, frozen, gate}, e.val);
        end
    end

    task automatic drive(input int h, input int v, input logic h_s, input logic v_s, input logic b_l,
                         input logic [1:0] sc, input logic [16:0] a, input logic [15:0] d,
                         input bit chk, input logic [11:0] ep, input int id);
        hcount = 11'(h);
        vcount = 10'(v);
        hs = h_s;
        vs = v_s;
        bl = b_l;
        scale = sc;
        addr_sched[cyc + 2] = a;
        dout_sched[cyc + 5] = d;
        if (chk) begin
            qpix.push_back('{cyc + 6, {2'b00, b_l, v_s, h_s, ep}, id});
            qaddr.push_back('{cyc + 3, a, id});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive(50, 100, 1'b0, 1'b0, 1'b0, 2'd0, 17'h15555, 16'hFFFF, 1'b0, 12'h000, 0);
        end
    endtask

    task automatic fstart();
        @(posedge clk);
        #1;
        drive(0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 17'h15555, 16'hFFFF, 1'b0, 12'h000, 0);
    endtask

    task automatic fsm_exp(input int off, input logic fz, input logic g);
        qfsm.push_back('{cyc + off, {15'b0, fz, g}, nfsm});
        nfsm++;
    endtask

    task automatic reset_exp(input int id);
        qpix.push_back('{cyc, 17'h04000, id});
        qaddr.push_back('{cyc, 17'h0, id});
        qfsm.push_back('{cyc, 17'h1, id});
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{10,  5,   1'b0, 1'b0, 1'b0, 2'd0, 16'hF800, 12'hF00};
        vecs[1]  = '{300, 5,   1'b0, 1'b0, 1'b0, 2'd0, 16'hFFFF, 12'h000};
        vecs[2]  = '{300, 5,   1'b0, 1'b0, 1'b0, 2'd1, 16'hFFFF, 12'hFFF};
        vecs[3]  = '{10,  5,   1'b1, 1'b0, 1'b1, 2'd0, 16'hFFFF, 12'h000};
        vecs[4]  = '{239, 319, 1'b0, 1'b1, 1'b0, 2'd0, 16'h07E0, 12'h0F0};
        vecs[5]  = '{10,  320, 1'b0, 1'b0, 1'b0, 2'd0, 16'hFFFF, 12'h000};
        vecs[6]  = '{240, 0,   1'b0, 1'b0, 1'b0, 2'd0, 16'hFFFF, 12'h000};
        vecs[7]  = '{479, 479, 1'b1, 1'b1, 1'b0, 2'd1, 16'h001F, 12'h00F};
        vecs[8]  = '{480, 100, 1'b0, 1'b0, 1'b0, 2'd1, 16'hFFFF, 12'h000};
        vecs[9]  = '{639, 479, 1'b0, 1'b0, 1'b0, 2'd2, 16'hA5A5, 12'hAB2};
        vecs[10] = '{640, 10,  1'b0, 1'b0, 1'b0, 2'd2, 16'hFFFF, 12'h000};
        vecs[11] = '{0,   480, 1'b0, 1'b0, 1'b0, 2'd2, 16'hFFFF, 12'h000};
        vecs[12] = '{200, 10,  1'b0, 1'b0, 1'b0, 2'd3, 16'h1234, SC3_PIX};
        vecs[13] = '{700, 10,  1'b0, 1'b0, 1'b0, 2'd3, 16'hFFFF, 12'h000};
        vecs[14] = '{200, 10,  1'b0, 1'b0, 1'b0, 2'd2, 16'h1234, 12'h14A};

        // Reset held with in-region, active-sync inputs present
        rst_n = 1'b0;
        freeze = 1'b0;
        hcount = 11'd10;
        vcount = 10'd5;
        hs = 1'b1;
        vs = 1'b1;
        bl = 1'b0;
        scale = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_exp(100);

        // Release and present the first raster position in the same cycle
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            drive(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].bl, vecs[i].sc,
                  (i == 0) ? 17'd1210 : 17'(2000 + i * 37), vecs[i].dout, 1'b1, vecs[i].epix, i);
        end
        idle(8);

        // Freeze request mid-frame waits for the frame boundary
        idle(1);
        freeze = 1'b1;
        fsm_exp(1, 1'b0, 1'b1);
        idle(2);
        fsm_exp(0, 1'b0, 1'b1);
        fstart();
        fsm_exp(0, 1'b0, 1'b1);
        fsm_exp(1, 1'b1, 1'b0);
        idle(2);
        fsm_exp(0, 1'b1, 1'b0);
        // Thaw request: gate stays closed until the next frame start
        freeze = 1'b0;
        fsm_exp(1, 1'b0, 1'b0);
        idle(2);
        fsm_exp(0, 1'b0, 1'b0);
        // Re-request while thaw is pending goes straight back to frozen
        freeze = 1'b1;
        fsm_exp(1, 1'b1, 1'b0);
        idle(1);
        freeze = 1'b0;
        fsm_exp(1, 1'b0, 1'b0);
        idle(1);
        fstart();
        fsm_exp(1, 1'b0, 1'b1);
        idle(1);
        // Request coincident with frame start only goes pending
        fstart();
        freeze = 1'b1;
        fsm_exp(1, 1'b0, 1'b1);
        idle(1);
        fsm_exp(0, 1'b0, 1'b1);
        fstart();
        fsm_exp(1, 1'b1, 1'b0);
        idle(2);
        fsm_exp(0, 1'b1, 1'b0);

        // One-cycle reset pulse mid-line while frozen
        @(posedge clk);
        #1;
        drive(50, 100, 1'b0, 1'b0, 1'b0, 2'd0, 17'h15555, 16'hFFFF, 1'b0, 12'h000, 0);
        rst_n = 1'b0;
        reset_exp(101);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        freeze = 1'b0;
        drive(50, 100, 1'b0, 1'b0, 1'b0, 2'd0, 17'h15555, 16'hFFFF, 1'b0, 12'h000, 0);
        fsm_exp(1, 1'b0, 1'b1);
        idle(8);

        @(negedge clk);
        foreach (qpix[i])  missed("pix", qpix[i].id, qpix[i].due);
        foreach (qaddr[i]) missed("bram_addr", qaddr[i].id, qaddr[i].due);
        foreach (qfsm[i])  missed("fsm", qfsm[i].id, qfsm[i].due);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
